mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. Consumes the 106-bit EX_MEM bus, performs data-RAM loads and stores, and hosts the memory-mapped peripherals: timer with interrupt, LED register and free-running systick. It selects the write-back value, drives the forwarding sources read by EX, and registers the MEM_WB bus consumed by write-back.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_if.sv | 21 ++
 rtl/mem_timer.sv | 52 +++++
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: write-back select codes, peripheral
// offsets, TCON bit positions and the EX_MEM / MEM_WB bus layouts.
package mem_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_LINK = 2'b11
    } memtoreg_e;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_ST = 2;

    localparam int unsigned EXM_SDATA_LSB = 0;
    localparam int unsigned EXM_ADDR_LSB  = 32;
    localparam int unsigned EXM_RD_LSB    = 64;
    localparam int unsigned EXM_MEMREAD   = 69;
    localparam int unsigned EXM_MEMWRITE  = 70;
    localparam int unsigned EXM_REGWRITE  = 71;
    localparam int unsigned EXM_M2R_LSB   = 72;
    localparam int unsigned EXM_PC4_LSB   = 74;
    localparam int unsigned EX_MEM_W      = 106;

    localparam int unsigned MWB_DATA_LSB  = 0;
    localparam int unsigned MWB_RD_LSB    = 32;
    localparam int unsigned MWB_REGWRITE  = 37;
    localparam int unsigned MEM_WB_W      = 38;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [31:0] pc4;
        memtoreg_e   memtoReg;
        logic        regWrite;
        logic        memWrite;
        logic        memRead;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] sdata;
    } ex_mem_t;

endpackage

// File: rtl/mem_if.sv
// EX->MEM->WB pipeline bus: EX_MEM in, forwarding sources and MEM_WB out.
interface mem_if;
    import mem_pkg::*;

    logic [EX_MEM_W-1:0] EX_MEM;
    logic                MEM_RegWrite;
    logic [4:0]          MEM_WriteRegister;
    logic [31:0]         MEM_RegWriteData;
    logic [MEM_WB_W-1:0] MEM_WB;

    modport master (
        output EX_MEM,
        input  MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData, MEM_WB
    );

    modport slave (
        input  EX_MEM,
        output MEM_RegWrite, MEM_WriteRegister, MEM_RegWriteData, MEM_WB
    );

endinterface

// File: rtl/mem_timer.sv
// Reloading 32-bit timer: TH reload, TL counter, TCON enable/int-enable/status.
module mem_timer
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrEn,
    input  logic [31:0] wrOff,
    input  logic [31:0] wrData,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic tlMax;
    logic setStatus;
    logic thWe, tlWe, tconWe;

    assign tlMax     = (tl == '1);
    assign setStatus = tcon[TCON_EN] && tlMax && tcon[TCON_IE];
    assign thWe      = wrEn && (wrOff == OFF_TH);
    assign tlWe      = wrEn && (wrOff == OFF_TL);
    assign tconWe    = wrEn && (wrOff == OFF_TCON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (thWe)
                th <= wrData;

            if (tlWe)
                tl <= wrData;
            else if (tcon[TCON_EN])
                tl <= tlMax ? th : tl + 32'd1;

            // A store racing an overflow keeps the status bit set.
            if (tconWe) begin
                tcon[TCON_IE:TCON_EN] <= wrData[TCON_IE:TCON_EN];
                tcon[TCON_ST]         <= wrData[TCON_ST] | setStatus;
            end else if (setStatus) begin
                tcon[TCON_ST] <= 1'b1;
            end
        end
    end

    assign irq = tcon[TCON_ST];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data RAM, LED/SYSTICK peripherals, write-back select.
// Timer peripheral (TH/TL/TCON, irq) is present only when MEM_TIMER_EN is defined.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_if.slave       bus,
    output logic [7:0] led,
    output logic       irq
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);

    ex_mem_t          exm;
    logic             isRam;
    logic [IDX_W-1:0] ramIdx;
    logic [31:0]      periphOff;
    logic             periphWe;
    logic [31:0]      rdData;
    logic [31:0]      wbData;
    logic [7:0]       ledReg;
    logic [31:0]      systick;
    logic [31:0]      thRd, tlRd;
    logic [2:0]       tconRd;
    logic             unusedAddrLsb;

    logic [31:0] ram [RAM_WORDS];

    assign exm = bus.EX_MEM;

    // Accesses are word-wide; the byte offset is deliberately dropped.
    assign unusedAddrLsb = ^exm.addr[1:0];
    assign isRam     = (exm.addr[31:IDX_W+2] == '0);
    assign ramIdx    = exm.addr[IDX_W+1:2];
    assign periphOff = {exm.addr[31:2], 2'b00} - PERIPH_BASE;
    assign periphWe  = exm.memWrite && !isRam;

`ifdef MEM_TIMER_EN
    mem_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (periphWe),
        .wrOff  (periphOff),
        .wrData (exm.sdata),
        .th     (thRd),
        .tl     (tlRd),
        .tcon   (tconRd),
        .irq    (irq)
    );
`else
    assign thRd   = '0;
    assign tlRd   = '0;
    assign tconRd = '0;
    assign irq    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (exm.memWrite && isRam)
            ram[ramIdx] <= exm.sdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledReg  <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (periphWe && (periphOff == OFF_LED))
                ledReg <= exm.sdata[7:0];
        end
    end

    always_comb begin
        rdData = '0;
        if (exm.memRead) begin
            if (isRam) begin
                rdData = ram[ramIdx];
            end else begin
                case (periphOff)
                    OFF_TH:      rdData = thRd;
                    OFF_TL:      rdData = tlRd;
                    OFF_TCON:    rdData = {29'b0, tconRd};
                    OFF_LED:     rdData = {24'b0, ledReg};
                    OFF_SYSTICK: rdData = systick;
                    default:     rdData = '0;
                endcase
            end
        end
    end

    always_comb begin
        wbData = exm.pc4;
        unique case (exm.memtoReg)
            WB_ALU:  wbData = exm.addr;
            WB_MEM:  wbData = rdData;
            default: wbData = exm.pc4;
        endcase
    end

    assign bus.MEM_RegWrite      = exm.regWrite;
    assign bus.MEM_WriteRegister = exm.rd;
    assign bus.MEM_RegWriteData  = wbData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.MEM_WB <= '0;
        else
            bus.MEM_WB <= {exm.regWrite, exm.rd, wbData};
    end

    assign led = ledReg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural model checked every cycle.
module tb_mem_stage;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef MEM_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led;
    logic       irq;

    mem_if bus();

    mem_stage #(.RAM_WORDS(256), .PERIPH_BASE(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .led   (led),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mRam [256];
    bit          mKnown [256];
    logic [31:0] mTh, mTl, mSys;
    logic [2:0]  mTcon;
    logic [7:0]  mLed;
    logic [37:0] mWb;
    bit          mWbKnown;

    task automatic modelReset();
        mTh = 0; mTl = 0; mSys = 0; mTcon = 0; mLed = 0;
        mWb = 0; mWbKnown = 1;
    endtask

    task automatic mRead(input logic [31:0] a, output logic [31:0] d, output bit known);
        known = 1;
        d = 0;
        if (a < 32'd1024) begin
            known = mKnown[a[9:2]];
            d = mRam[a[9:2]];
        end else begin
            case ({a[31:2], 2'b00})
                BASE + 32'h00: d = TIMER_ON ? mTh : 32'h0;
                BASE + 32'h04: d = TIMER_ON ? mTl : 32'h0;
                BASE + 32'h08: d = TIMER_ON ? {29'h0, mTcon} : 32'h0;
                BASE + 32'h0C: d = {24'h0, mLed};
                BASE + 32'h14: d = mSys;
                default:       d = 0;
            endcase
        end
    endtask

    task automatic modelOut(input logic [105:0] v, output logic [31:0] wb, output bit known);
        logic [31:0] rd;
        bit k;
        if (v[69]) mRead(v[63:32], rd, k);
        else begin rd = 0; k = 1; end
        case (v[73:72])
            2'b00:   begin wb = v[63:32];  known = 1; end
            2'b01:   begin wb = rd;        known = k; end
            default: begin wb = v[105:74]; known = 1; end
        endcase
    endtask

    task automatic modelStep(input logic [105:0] v);
        logic [31:0] wb, a, sd, nextTl;
        logic [2:0]  nextTcon;
        bit k, ovf;
        modelOut(v, wb, k);
        mWb = {v[71], v[68:64], wb};
        mWbKnown = k;
        a  = {v[63:34], 2'b00};
        sd = v[31:0];
        nextTl = mTl;
        nextTcon = mTcon;
        ovf = 0;
        if (TIMER_ON && mTcon[0]) begin
            if (mTl == 32'hFFFF_FFFF) begin
                nextTl = mTh;
                ovf = mTcon[1];
            end else begin
                nextTl = mTl + 1;
            end
        end
        if (ovf) nextTcon[2] = 1'b1;
        if (v[70]) begin
            if (a < 32'd1024) begin
                mRam[a[9:2]] = sd;
                mKnown[a[9:2]] = 1;
            end else if (a == BASE + 32'h0C) begin
                mLed = sd[7:0];
            end else if (TIMER_ON && a == BASE + 32'h00) begin
                mTh = sd;
            end else if (TIMER_ON && a == BASE + 32'h04) begin
                nextTl = sd;
            end else if (TIMER_ON && a == BASE + 32'h08) begin
                nextTcon = {sd[2] | ovf, sd[1:0]};
            end
        end
        mTl = nextTl;
        mTcon = nextTcon;
        mSys = mSys + 1;
    endtask

    // One compare process: outputs at negedge, model advance at posedge.
    initial begin
        forever begin
            logic [31:0] wb;
            bit k;
            @(negedge clk);
            if (!rst_n) modelReset();
            modelOut(bus.EX_MEM, wb, k);
            chk("fwd_regwrite", bus.MEM_RegWrite, bus.EX_MEM[71]);
            chk("fwd_writereg", bus.MEM_WriteRegister, bus.EX_MEM[68:64]);
            if (k) chk("fwd_wbdata", bus.MEM_RegWriteData, wb);
            if (mWbKnown) chk("mem_wb", bus.MEM_WB, mWb);
            chk("led", led, mLed);
            chk("irq", irq, TIMER_ON ? mTcon[2] : 1'b0);
            @(posedge clk);
            if (!rst_n) modelReset();
            else modelStep(bus.EX_MEM);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [105:0] mk(input logic [31:0] pc4, input logic [1:0] m2r,
                                        input logic rw, input logic mw, input logic mr,
                                        input logic [4:0] rd, input logic [31:0] addr,
                                        input logic [31:0] sd);
        return {pc4, m2r, rw, mw, mr, rd, addr, sd};
    endfunction

    function automatic logic [105:0] st(input logic [31:0] a, input logic [31:0] d);
        return mk(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, a, d);
    endfunction

    function automatic logic [105:0] ld(input logic [31:0] a, input logic [4:0] rd);
        return mk(32'h0, 2'b01, 1'b1, 1'b0, 1'b1, rd, a, 32'h0);
    endfunction

    task automatic go(input logic [105:0] v);
        @(posedge clk);
        #1 bus.EX_MEM = v;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.EX_MEM = '0;
        for (int i = 0; i < 256; i++) mKnown[i] = 0;
        modelReset();
        #1;
        chk("reset_mem_wb", bus.MEM_WB, 38'h0);
        chk("reset_led", led, 8'h0);
        chk("reset_irq", irq, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Store then load, zero-cycle result and registered MEM_WB
        go(st(32'h10, 32'hDEAD_BEEF));
        go(ld(32'h10, 5'd8));
        chk("load_data", bus.MEM_RegWriteData, 32'hDEAD_BEEF);
        chk("load_dest", bus.MEM_WriteRegister, 5'd8);
        go('0);
        chk("load_mem_wb", bus.MEM_WB, {1'b1, 5'd8, 32'hDEAD_BEEF});
        go(ld(32'h12, 5'd6));
        chk("load_unaligned", bus.MEM_RegWriteData, 32'hDEAD_BEEF);

        // Write-back select
        go(mk(32'h40, 2'b10, 1'b1, 1'b0, 1'b0, 5'd31, 32'h1234, 32'h0));
        chk("jal_link", bus.MEM_RegWriteData, 32'h40);
        go(mk(32'h80, 2'b11, 1'b1, 1'b0, 1'b0, 5'd30, 32'h1234, 32'h0));
        chk("jal_wb_rd", bus.MEM_WB[36:32], 5'd31);
        chk("jal_wb_data", bus.MEM_WB[31:0], 32'h40);
        go(mk(32'h40, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 32'hABCD, 32'h0));
        chk("alu_result", bus.MEM_RegWriteData, 32'hABCD);

        // Read and write in one cycle returns the old word
        go(st(32'h20, 32'h1));
        go(mk(32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd4, 32'h20, 32'h2));
        chk("rw_same_old", bus.MEM_RegWriteData, 32'h1);
        go(ld(32'h20, 5'd4));
        chk("rw_same_new", bus.MEM_RegWriteData, 32'h2);
        go(ld(32'h3FC, 5'd4));
        go(st(32'h3FC, 32'h0BAD_F00D));
        go(ld(32'h3FC, 5'd4));
        chk("ram_top_word", bus.MEM_RegWriteData, 32'h0BAD_F00D);

        // LED, unmapped, SYSTICK
        go(st(BASE + 32'h0C, 32'h5A));
        go('0);
        chk("led_store", led, 8'h5A);
        go(ld(BASE + 32'h0C, 5'd2));
        chk("led_load", bus.MEM_RegWriteData, 32'h5A);
        go(st(BASE + 32'h20, 32'hFFFF_FFFF));
        go(ld(BASE + 32'h20, 5'd4));
        chk("unmapped_load", bus.MEM_RegWriteData, 32'h0);
        go(ld(BASE + 32'h14, 5'd1));
        go(st(BASE + 32'h14, 32'h0));
        go(ld(BASE + 32'h14, 5'd1));
        go(mk(32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd1, BASE + 32'h14, 32'h0));
        chk("no_memread_zero", bus.MEM_RegWriteData, 32'h0);

        // Timer reload and interrupt
        go(st(BASE + 32'h00, 32'hFFFF_FFF0));
        go(st(BASE + 32'h04, 32'hFFFF_FFFE));
        go(st(BASE + 32'h08, 32'h3));
        go(ld(BASE + 32'h04, 5'd5));
`ifdef MEM_TIMER_EN
        chk("tl_start", bus.MEM_RegWriteData, 32'hFFFF_FFFE);
`else
        chk("tl_unmapped", bus.MEM_RegWriteData, 32'h0);
`endif
        go(ld(BASE + 32'h04, 5'd5));
`ifdef MEM_TIMER_EN
        chk("tl_max", bus.MEM_RegWriteData, 32'hFFFF_FFFF);
        chk("irq_before_ovf", irq, 1'b0);
`endif
        go(ld(BASE + 32'h04, 5'd5));
`ifdef MEM_TIMER_EN
        chk("tl_reload", bus.MEM_RegWriteData, 32'hFFFF_FFF0);
        chk("irq_after_ovf", irq, 1'b1);
`endif
        go(st(BASE + 32'h08, 32'h3));
        go('0);
        chk("irq_cleared", irq, 1'b0);

        // Overflow coinciding with a TCON store
        go(st(BASE + 32'h04, 32'hFFFF_FFFE));
        go('0);
        go(st(BASE + 32'h08, 32'h3));
        go(ld(BASE + 32'h08, 5'd7));
`ifdef MEM_TIMER_EN
        chk("irq_race_kept", irq, 1'b1);
        chk("tcon_race_read", bus.MEM_RegWriteData, 32'h7);
`else
        chk("irq_tied_low", irq, 1'b0);
`endif
        go(st(BASE + 32'h08, 32'h3));
        go('0);

        // Asynchronous reset mid-count
        go(st(BASE + 32'h0C, 32'hA5));
        go(st(BASE + 32'h04, 32'hFFFF_FFFE));
        go('0);
        go(mk(32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd9, 32'h77, 32'h0));
        go(ld(BASE + 32'h04, 5'd7));
        chk("pre_reset_led", led, 8'hA5);
        chk("pre_reset_mem_wb", bus.MEM_WB, {1'b1, 5'd9, 32'h77});
`ifdef MEM_TIMER_EN
        chk("pre_reset_irq", irq, 1'b1);
`endif
        rst_n = 1'b0;
        #1;
        chk("async_irq", irq, 1'b0);
        chk("async_led", led, 8'h0);
        chk("async_mem_wb", bus.MEM_WB, 38'h0);
        chk("async_tl", bus.MEM_RegWriteData, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        go(ld(BASE + 32'h14, 5'd1));
        chk("systick_restart", bus.MEM_RegWriteData, 32'h1);
        go(ld(32'h10, 5'd8));
        chk("ram_survives_reset", bus.MEM_RegWriteData, 32'hDEAD_BEEF);
        go('0);
        go('0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
